// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM path. One frame per ss_n low
// period: a 2-bit command, then a DATA_W-bit payload, MSB first. Read-data
// frames return a RAM word on miso, loaded through a tx handshake with timeout.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              read_pending,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    // Keep the wait counter at least one bit wide when the timeout is disabled.
    localparam int unsigned TO_W  = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);

    localparam logic [1:0] CmdRdAddr = 2'b10;
    localparam logic [1:0] CmdRdData = 2'b11;

    localparam logic [1:0] ErrAbort   = 2'b01;
    localparam logic [1:0] ErrNoRead  = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRx,
        StWaitTx,
        StTx,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                miso_q, miso_d;
    logic [DATA_W+1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rp_q, rp_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    // Next-state and output logic; ss_n high outranks every other event.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        shreg_d    = shreg_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rp_d       = rp_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (state_q != StIdle && ss_n) begin
            state_d = StIdle;
            miso_d  = 1'b0;
            if (state_q != StDone) begin
                err_d      = 1'b1;
                err_code_d = ErrAbort;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!ss_n) begin
                        cmd_d[1] = mosi;
                        state_d  = StCmd;
                    end
                end
                StCmd: begin
                    cmd_d[0] = mosi;
                    if ({cmd_q[1], mosi} == CmdRdData && !rp_q) begin
                        err_d      = 1'b1;
                        err_code_d = ErrNoRead;
                        state_d    = StDone;
                    end else begin
                        cnt_d   = '0;
                        state_d = StRx;
                    end
                end
                StRx: begin
                    shreg_d = {shreg_q[DATA_W-2:0], mosi};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {cmd_q, shreg_q[DATA_W-2:0], mosi};
                        if (cmd_q == CmdRdAddr) begin
                            rp_d = 1'b1;
                        end
                        if (cmd_q == CmdRdData) begin
                            wait_d  = '0;
                            state_d = StWaitTx;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StWaitTx: begin
                    if (tx_valid) begin
                        shreg_d = tx_data;
                        miso_d  = tx_data[DATA_W-1];
                        cnt_d   = CNT_W'(1);  // bits already placed on miso
                        state_d = StTx;
                    end else if (TX_TIMEOUT != 0 && wait_q == TO_W'(TX_TIMEOUT - 1)) begin
                        err_d      = 1'b1;
                        err_code_d = ErrTimeout;
                        state_d    = StDone;
                    end else begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                StTx: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        rp_d    = 1'b0;
                        miso_d  = 1'b0;
                        state_d = StDone;
                    end else begin
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                        miso_d  = shreg_q[DATA_W-2];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            shreg_q    <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rp_q       <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            shreg_q    <= shreg_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rp_q       <= rp_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign miso         = miso_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign read_pending = rp_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: directed and random frames on an 8-bit instance
// checked edge by edge against a frame-level model, plus a 16-bit instance.
module tb_spi_slave_param;

    localparam int W  = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n, ss_n, mosi, tx_valid;
    logic [W-1:0]  tx_data;
    logic          miso, rx_valid, read_pending, err;
    logic [W+1:0]  rx_data;
    logic [1:0]    err_code;

    logic [15:0]   tx_data16;
    logic          miso16, rx_valid16, rp16, err16;
    logic [17:0]   rx_data16;
    logic [1:0]    err_code16;

    spi_slave_param #(.DATA_W(W), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .read_pending(read_pending), .err(err), .err_code(err_code)
    );

    spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16),
        .tx_valid(tx_valid), .read_pending(rp16), .err(err16), .err_code(err_code16)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Frame-level model of the 8-bit instance.
    logic         rp_m   = 1'b0;
    logic [W+1:0] rxd_m  = '0;
    logic [1:0]   code_m = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all8(input string tag, input logic e_miso, input logic e_rv,
                            input logic e_err);
        chk({tag, ".miso"}, 32'(miso), 32'(e_miso));
        chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(e_rv));
        chk({tag, ".rx_data"}, 32'(rx_data), 32'(rxd_m));
        chk({tag, ".read_pending"}, 32'(read_pending), 32'(rp_m));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".err_code"}, 32'(err_code), 32'(code_m));
    endtask

    // One frame on the 8-bit instance. abort_at: edge index with ss_n high (-1 none).
    // d: tx_valid delay in edges after WAIT_TX is reachable (-1 never, 0 held high).
    task automatic frame(input string tag, input logic [1:0] cmd, input logic [W-1:0] pay,
                         input int abort_at, input int d, input logic [W-1:0] txw);
        logic [W+1:0] bits;
        logic rej, served, e_err, e_rv, e_miso;
        int done_e, last_e, start;
        bits   = {cmd, pay};
        rej    = (cmd == 2'b11) && !rp_m;
        served = (cmd == 2'b11) && !rej && (d >= 0);
        start  = W + 2 + d;
        if (rej)                done_e = 1;
        else if (cmd != 2'b11)  done_e = W + 1;
        else if (d < 0)         done_e = W + 1 + TO;
        else                    done_e = 2 * W + 2 + d;
        last_e = (abort_at >= 0) ? abort_at : done_e + 2;
        for (int k = 0; k <= last_e; k++) begin
            @(negedge clk);
            ss_n    = (k == abort_at);
            mosi    = (k < W + 2) ? bits[W+1-k] : 1'($urandom);
            tx_data = txw;
            if (cmd == 2'b11) tx_valid = (d == 0) || (d > 0 && k >= start);
            else              tx_valid = 1'($urandom);
            @(posedge clk);
            #1;
            e_err = 1'b0; e_rv = 1'b0; e_miso = 1'b0;
            if (k == abort_at) begin
                if (k >= 1 && k <= done_e) begin
                    e_err  = 1'b1;
                    code_m = 2'b01;
                end
            end else begin
                if (rej && k == 1) begin
                    e_err  = 1'b1;
                    code_m = 2'b10;
                end
                if (!rej && k == W + 1) begin
                    e_rv  = 1'b1;
                    rxd_m = bits;
                    if (cmd == 2'b10) rp_m = 1'b1;
                end
                if (cmd == 2'b11 && !rej && d < 0 && k == W + 1 + TO) begin
                    e_err  = 1'b1;
                    code_m = 2'b11;
                end
                if (served && k == done_e) rp_m = 1'b0;
                if (served && k >= start && k <= start + W - 1) e_miso = txw[W-1-(k-start)];
            end
            chk_all8(tag, e_miso, e_rv, e_err);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ss_n     = 1'b1;
            mosi     = 1'($urandom);
            tx_valid = 1'b0;
            @(posedge clk);
            #1;
            chk_all8({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Drives n edges of ss_n low on the shared lines, 18-bit frame MSB first.
    task automatic send16(input logic [17:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ss_n = 1'b0;
            mosi = (k < 18) ? bits[17-k] : 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_ss();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ss_n = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] txw16;
        logic [1:0]  rcmd;
        int          rd, ra;

        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
        tx_data = '0; tx_data16 = '0;
        #1;
        chk_all8("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        frame("wr_data", 2'b01, 8'hA5, -1, 0, 8'h00);
        chk("wr_data.const", 32'(rx_data), 32'h1A5);
        frame("rd_addr", 2'b10, 8'h03, -1, 0, 8'h00);
        chk("rd_addr.pending", 32'(read_pending), 32'h1);
        frame("rd_data", 2'b11, 8'($urandom), -1, 0, 8'hC3);
        chk("rd_data.cleared", 32'(read_pending), 32'h0);
        frame("no_pend", 2'b11, 8'($urandom), -1, 0, 8'h3C);
        chk("no_pend.code", 32'(err_code), 32'h2);
        frame("rd_addr2", 2'b10, 8'h40, -1, 0, 8'h00);
        frame("timeout", 2'b11, 8'($urandom), -1, -1, 8'hFF);
        chk("timeout.code", 32'(err_code), 32'h3);
        chk("timeout.pending", 32'(read_pending), 32'h1);
        frame("abort9", 2'b01, 8'h5A, 9, 0, 8'h00);
        chk("abort9.code", 32'(err_code), 32'h1);
        frame("rd_late", 2'b11, 8'($urandom), -1, 3, 8'h96);
        frame("abort_tx", 2'b10, 8'h11, -1, 0, 8'h00);
        frame("abort_tx", 2'b11, 8'h00, 14, 1, 8'h7E);

        for (int i = 0; i < 40; i++) begin
            rcmd = 2'($urandom);
            rd   = int'($urandom_range(0, 4)) - 1;
            ra   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * W + 6)) : -1;
            frame("rand", rcmd, 8'($urandom), ra, rd, 8'($urandom));
        end

        // 16-bit instance: write frame, read address, then reset during TX.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        txw16    = 16'($urandom) | 16'h0400;
        tx_data16 = txw16;
        tx_valid = 1'b1;
        send16({2'b00, 16'hBEEF}, 18);
        chk("w16.rx_valid", 32'(rx_valid16), 32'h1);
        chk("w16.rx_data", 32'(rx_data16), 32'h0BEEF);
        release_ss();
        chk("w16.hold", 32'(rx_data16), 32'h0BEEF);
        chk("w16.err", 32'(err16), 32'h0);
        send16({2'b10, 16'h0004}, 18);
        chk("a16.pending", 32'(rp16), 32'h1);
        release_ss();
        send16({2'b11, 16'h0000}, 24);
        chk("r16.miso", 32'(miso16), 32'(txw16[10]));
        chk("r16.pending", 32'(rp16), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst16.miso", 32'(miso16), 32'h0);
        chk("rst16.rx_data", 32'(rx_data16), 32'h0);
        chk("rst16.rx_valid", 32'(rx_valid16), 32'h0);
        chk("rst16.pending", 32'(rp16), 32'h0);
        chk("rst16.err", 32'(err16), 32'h0);
        chk("rst16.err_code", 32'(err_code16), 32'h0);
        rp_m = 1'b0; rxd_m = '0; code_m = 2'b00;
        chk_all8("rst8", 1'b0, 1'b0, 1'b0);
        ss_n = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front-end for the single-port RAM path. One frame per slave-select assertion; clk is the SPI serial clock. Each frame carries a 2-bit command plus a DATA_W-bit payload, sampled MSB first. Read-data frames return a RAM word on miso, loaded through a tx handshake with a timeout. Adds abort detection, read sequencing checks and error reporting.

## Interface
- DATA_W, 8, payload width in bits; legal range 2..32
- TX_TIMEOUT, 16, max clk cycles to wait for tx_valid; 0 = wait indefinitely
- clk  in  1  serial clock; all sampling and driving on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ss_n  in  1  slave select, active-low; one frame per low period
- mosi  in  1  serial data in
- miso  out  1  serial data out, registered
- rx_data  out  DATA_W+2  {cmd[1:0], payload}; holds until next rx_valid
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  DATA_W  read word from RAM
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX
- read_pending  out  1  read address accepted, read data not yet returned
- err  out  1  one-cycle error strobe
- err_code  out  2  01 abort, 10 read-data with no pending address, 11 tx timeout; holds until next err

## Operation
- Commands: 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, CMD, RX, WAIT_TX, TX, DONE.
- IDLE: ss_n low at an edge -> sample mosi as cmd[1], go CMD. Otherwise stay.
- CMD: sample cmd[0]. If cmd = 11 and read_pending = 0: err, err_code 10, go DONE, no rx_valid. Otherwise clear bit counter, go RX.
- RX: shift in DATA_W payload bits. The edge sampling the last bit sets rx_valid and loads rx_data = {cmd, payload}.
  - cmd 10: the same edge sets read_pending.
  - cmd 11: go WAIT_TX (payload is dummy, still reported).
  - Other commands: go DONE.
- WAIT_TX: on an edge with tx_valid high, load the shift register with tx_data, drive miso <= tx_data[DATA_W-1], go TX.
  - If TX_TIMEOUT != 0 and TX_TIMEOUT edges pass without tx_valid: err, err_code 11, go DONE. read_pending stays set.
- TX: each edge drives the next bit to miso, MSB first. After the LSB has been driven for one cycle: clear read_pending, miso <= 0, go DONE.
- DONE: ignore mosi; miso = 0; leave only when ss_n goes high.
- ss_n high at any edge in a non-IDLE state:
  - go IDLE, miso <= 0.
  - Pending rx_valid or tx action is discarded.
  - In CMD, RX, WAIT_TX or TX: err, err_code 01.
  - In DONE: no error.
  - ss_n takes priority over all simultaneous events, including the last payload bit.
- An abort or timeout does not change read_pending. A subsequent read address re-arms it (stays 1).
- Bit counter width is $clog2(DATA_W+1); it never wraps inside a frame.

## Timing
- Reset values: miso 0, rx_data 0, rx_valid 0, read_pending 0, err 0, err_code 00, state IDLE, counters 0.
- Frame bit k (k = 0 .. DATA_W+1) is sampled at the k-th rising edge with ss_n low, counting from 0 at the first such edge.
- rx_valid is high during the cycle after edge DATA_W+1, for exactly one cycle.
- For cmd 11 with tx_valid already high:
  - load at edge DATA_W+2
  - miso MSB valid in the cycle after edge DATA_W+2
  - LSB valid in the cycle after edge 2*DATA_W+1
- Each cycle of tx_valid delay shifts the miso window one cycle later.
- err is a one-cycle pulse, registered at the detecting edge.
- Asserting rst_n mid-frame returns all outputs to reset values immediately; read_pending is lost.

## Test plan
- Write-data frame, DATA_W=8, ss_n low, bits 01_10100101 -> rx_valid one cycle after bit 9, rx_data = 10'h1A5; err never pulses; DONE until ss_n high.
- Read-address 10_00000011, then a new frame with read-data 11_xxxxxxxx, tx_valid high with tx_data 8'hC3 -> read_pending 1 after first frame; miso outputs 1,1,0,0,0,0,1,1 starting the cycle after edge 10; read_pending 0 after LSB.
- Read-data frame with read_pending 0 -> err with err_code 10 at edge 1; no rx_valid; miso stays 0.
- Read-data frame, TX_TIMEOUT=4, tx_valid held low -> err with err_code 11 four edges after entering WAIT_TX; read_pending still 1.
- ss_n raised at the edge that would sample bit 9 of a write frame -> no rx_valid; err with err_code 01; state IDLE; rx_data unchanged.
- DATA_W=16 write frame 00 + 16'hBEEF; rst_n pulsed low mid-TX on a later read -> rx_data = 18'h0BEEF; after reset all outputs are 0.
